input_vc_state_table: RTL and testbench
=======================================

# input_vc_state_table

Per-input-VC state tracker for the router input side, and the successor to the single-field assigned-VC register file. For each of NINPUTS input VCs it holds a three-state packet lifecycle (IDLE → ROUTED → ACTIVE), the routed output port and the allocated output VC. It feeds VC-allocation requests to the VC allocator and the assigned port/VC to the switch-allocation and output path. It also detects protocol violations from the surrounding control logic.

## Interface
- VC_WIDTH, 1, width of an output-VC identifier
- PORT_WIDTH, 3, width of an output-port identifier
- NINPUTS, 10, number of input VCs tracked (≥2)

- clock  in  1  router clock
- reset  in  1  synchronous, active-high; one clock; clears all state
- route_valid  in  1  head flit routed this cycle
- route_ivc_sel  in  NINPUTS  one-hot input VC receiving the route
- route_oport  in  PORT_WIDTH  output port from route computation
- alloc_enable  in  1  VC allocator grant this cycle
- alloc_ivc_sel  in  NINPUTS  one-hot granted input VC
- allocated_vc  in  VC_WIDTH  granted output VC
- send_valid  in  1  flit leaves the input VC this cycle
- send_ivc_sel  in  NINPUTS  one-hot sending input VC
- send_tail  in  1  departing flit is a tail
- rd_ivc_sel  in  NINPUTS  one-hot read select
- assigned_vc  out  VC_WIDTH  output VC of the selected input VC
- assigned_port  out  PORT_WIDTH  output port of the selected input VC
- vc_req  out  NINPUTS  bit i = input VC i is ROUTED (requesting an output VC)
- vc_active  out  NINPUTS  bit i = input VC i is ACTIVE
- error  out  1  sticky protocol-violation flag

## Operation
- Per input VC i, the block holds: state (IDLE=0, ROUTED=1, ACTIVE=2), oport[i] (PORT_WIDTH bits) and ovc[i] (VC_WIDTH bits).
- An event "hits" input VC i when its valid/enable is high and bit i of its select is set.
- State transitions:
  - IDLE + route hit → ROUTED. oport[i] ← route_oport; ovc[i] ← 0.
  - ROUTED + alloc hit → ACTIVE. ovc[i] ← allocated_vc.
  - ACTIVE + send hit with send_tail=1 → IDLE. oport[i] and ovc[i] are retained (stale but harmless).
  - ACTIVE + send hit with send_tail=0 → no change.
  - ACTIVE + tail-send hit + route hit on the same i in the same cycle → ROUTED. oport[i] ← route_oport; ovc[i] ← 0. This is the back-to-back packet case and is legal.
- Events on different input VCs in the same cycle are independent and all take effect.
- Illegal events are ignored (no state/field change) and set error. Illegal events are:
  - a route hit on a VC that is not IDLE, other than the tail-release case above;
  - an alloc hit on a VC that is not ROUTED;
  - a send hit on a VC that is not ACTIVE;
  - any select that is not one-hot (zero or multiple bits set) while its valid/enable is high.
- error stays set until reset.
- Read path:
  - assigned_vc and assigned_port are a decoded one-hot mux over ovc/oport, indexed by rd_ivc_sel.
  - rd_ivc_sel all-zero gives 0.
  - rd_ivc_sel multi-hot gives the OR of the selected entries. This does not set error.
- vc_req and vc_active decode directly from the state registers.

## Timing
- All state updates occur on the rising clock edge. An update is visible on outputs in the cycle after the event.
- Read outputs are combinational from registers (0-cycle latency from rd_ivc_sel). They reflect the pre-edge state in the cycle of a concurrent write.
- The allocator sees vc_req high starting the cycle after the route hit.
- The earliest path is route in cycle N, alloc in N+1, send in N+2.
- Reset values: all states IDLE; oport, ovc, vc_req, vc_active, error, assigned_vc and assigned_port all 0.
- Reset asserted mid-packet (any state) forces IDLE on the next edge and overrides all concurrent events.
- Event inputs are ignored while reset is high.

## Test plan
- Reset then idle, with NINPUTS=10, VC_WIDTH=2, PORT_WIDTH=3 → all outputs 0, error=0.
- Full lifecycle on VC 3:
  - route_oport=5 → next cycle vc_req=0x008.
  - Alloc allocated_vc=2 → vc_active=0x008; rd_ivc_sel=0x008 gives assigned_port=5, assigned_vc=2.
  - Body send → unchanged.
  - Tail send → vc_active=0.
- Back-to-back on VC 7: ACTIVE with ovc=1; same cycle tail send + route oport=2 → vc_req bit7=1, vc_active bit7=0, assigned_vc=0, assigned_port=2, error=0.
- Concurrent events: route VC0 (oport 1), alloc VC4 (ovc 3, VC4 ROUTED) and tail send VC9 (ACTIVE) in one cycle → all three transitions occur; error=0.
- Violations, each applied from a fresh reset, each leaves state unchanged and sets error=1, which stays set until reset:
  - alloc on IDLE VC2;
  - route on ACTIVE VC5 without tail;
  - send_ivc_sel=0x003.
- Reset mid-operation: VCs 1, 2 and 6 in mixed states, assert reset one cycle → all states IDLE, error=0, reads 0.

Source files
------------

// File: rtl/input_vc_state_table.sv
// Per-input-VC packet lifecycle tracker (IDLE -> ROUTED -> ACTIVE) holding the
// routed output port and allocated output VC, with sticky protocol-violation detection.
module input_vc_state_table #(
    parameter int VC_WIDTH   = 1,
    parameter int PORT_WIDTH = 3,
    parameter int NINPUTS    = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  route_valid,
    input  logic [NINPUTS-1:0]    route_ivc_sel,
    input  logic [PORT_WIDTH-1:0] route_oport,
    input  logic                  alloc_enable,
    input  logic [NINPUTS-1:0]    alloc_ivc_sel,
    input  logic [VC_WIDTH-1:0]   allocated_vc,
    input  logic                  send_valid,
    input  logic [NINPUTS-1:0]    send_ivc_sel,
    input  logic                  send_tail,
    input  logic [NINPUTS-1:0]    rd_ivc_sel,
    output logic [VC_WIDTH-1:0]   assigned_vc,
    output logic [PORT_WIDTH-1:0] assigned_port,
    output logic [NINPUTS-1:0]    vc_req,
    output logic [NINPUTS-1:0]    vc_active,
    output logic                  error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTED = 2'd1,
        ACTIVE = 2'd2
    } vc_state_e;

    vc_state_e             state_q [NINPUTS];
    vc_state_e             state_d [NINPUTS];
    logic [PORT_WIDTH-1:0] oport_q [NINPUTS];
    logic [PORT_WIDTH-1:0] oport_d [NINPUTS];
    logic [VC_WIDTH-1:0]   ovc_q   [NINPUTS];
    logic [VC_WIDTH-1:0]   ovc_d   [NINPUTS];
    logic                  error_q;
    logic                  error_d;

    logic                  route_ok;
    logic                  alloc_ok;
    logic                  send_ok;
    logic [NINPUTS-1:0]    route_hit;
    logic [NINPUTS-1:0]    alloc_hit;
    logic [NINPUTS-1:0]    send_hit;
    logic                  violation;

    function automatic logic is_onehot(input logic [NINPUTS-1:0] v);
        int cnt;
        cnt = 0;
        for (int k = 0; k < NINPUTS; k++) begin
            if (v[k]) cnt++;
        end
        return (cnt == 1);
    endfunction

    // A malformed select drops the whole event; it only raises the error flag.
    assign route_ok  = is_onehot(route_ivc_sel);
    assign alloc_ok  = is_onehot(alloc_ivc_sel);
    assign send_ok   = is_onehot(send_ivc_sel);
    assign route_hit = (route_valid  && route_ok) ? route_ivc_sel : '0;
    assign alloc_hit = (alloc_enable && alloc_ok) ? alloc_ivc_sel : '0;
    assign send_hit  = (send_valid   && send_ok)  ? send_ivc_sel  : '0;

    always_comb begin
        violation = 1'b0;
        if (route_valid  && !route_ok) violation = 1'b1;
        if (alloc_enable && !alloc_ok) violation = 1'b1;
        if (send_valid   && !send_ok)  violation = 1'b1;

        for (int i = 0; i < NINPUTS; i++) begin
            state_d[i] = state_q[i];
            oport_d[i] = oport_q[i];
            ovc_d[i]   = ovc_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (route_hit[i]) begin
                        state_d[i] = ROUTED;
                        oport_d[i] = route_oport;
                        ovc_d[i]   = '0;
                    end
                    if (alloc_hit[i] || send_hit[i]) violation = 1'b1;
                end
                ROUTED: begin
                    if (alloc_hit[i]) begin
                        state_d[i] = ACTIVE;
                        ovc_d[i]   = allocated_vc;
                    end
                    if (route_hit[i] || send_hit[i]) violation = 1'b1;
                end
                ACTIVE: begin
                    // Tail departure frees the VC; a same-cycle route re-arms it back to back.
                    if (send_hit[i] && send_tail) begin
                        if (route_hit[i]) begin
                            state_d[i] = ROUTED;
                            oport_d[i] = route_oport;
                            ovc_d[i]   = '0;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else if (route_hit[i]) begin
                        violation = 1'b1;
                    end
                    if (alloc_hit[i]) violation = 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase
        end

        error_d = error_q | violation;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NINPUTS; i++) begin
                state_q[i] <= IDLE;
                oport_q[i] <= '0;
                ovc_q[i]   <= '0;
            end
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NINPUTS; i++) begin
                state_q[i] <= state_d[i];
                oport_q[i] <= oport_d[i];
                ovc_q[i]   <= ovc_d[i];
            end
            error_q <= error_d;
        end
    end

    // Multi-hot read selects OR the chosen entries together.
    always_comb begin
        assigned_vc   = '0;
        assigned_port = '0;
        for (int i = 0; i < NINPUTS; i++) begin
            vc_req[i]    = (state_q[i] == ROUTED);
            vc_active[i] = (state_q[i] == ACTIVE);
            if (rd_ivc_sel[i]) begin
                assigned_vc   = assigned_vc   | ovc_q[i];
                assigned_port = assigned_port | oport_q[i];
            end
        end
    end

    assign error = error_q;

endmodule

// File: tb/tb_input_vc_state_table.sv
// Directed table-driven bench for input_vc_state_table (NINPUTS=10, VC_WIDTH=2, PORT_WIDTH=3).
module tb_input_vc_state_table;

    localparam int NI = 10;
    localparam int VW = 2;
    localparam int PW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          route_valid;
    logic [NI-1:0] route_ivc_sel;
    logic [PW-1:0] route_oport;
    logic          alloc_enable;
    logic [NI-1:0] alloc_ivc_sel;
    logic [VW-1:0] allocated_vc;
    logic          send_valid;
    logic [NI-1:0] send_ivc_sel;
    logic          send_tail;
    logic [NI-1:0] rd_ivc_sel;
    logic [VW-1:0] assigned_vc;
    logic [PW-1:0] assigned_port;
    logic [NI-1:0] vc_req;
    logic [NI-1:0] vc_active;
    logic          error;

    input_vc_state_table #(.VC_WIDTH(VW), .PORT_WIDTH(PW), .NINPUTS(NI)) dut (
        .clock(clock), .reset(reset),
        .route_valid(route_valid), .route_ivc_sel(route_ivc_sel), .route_oport(route_oport),
        .alloc_enable(alloc_enable), .alloc_ivc_sel(alloc_ivc_sel), .allocated_vc(allocated_vc),
        .send_valid(send_valid), .send_ivc_sel(send_ivc_sel), .send_tail(send_tail),
        .rd_ivc_sel(rd_ivc_sel),
        .assigned_vc(assigned_vc), .assigned_port(assigned_port),
        .vc_req(vc_req), .vc_active(vc_active), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          rst;
        logic          rv;
        logic [NI-1:0] rsel;
        logic [PW-1:0] rop;
        logic          av;
        logic [NI-1:0] asel;
        logic [VW-1:0] avc;
        logic          sv;
        logic [NI-1:0] ssel;
        logic          tail;
        logic [NI-1:0] rd;
        logic [NI-1:0] e_req;
        logic [NI-1:0] e_act;
        logic [VW-1:0] e_vc;
        logic [PW-1:0] e_port;
        logic          e_err;
    } vec_t;

    vec_t vecs[40];
    int   nv = 0;
    int   applied = 0;
    int   miscompares = 0;

    task automatic add(input logic rst, input logic rv, input logic [NI-1:0] rsel, input logic [PW-1:0] rop,
                       input logic av, input logic [NI-1:0] asel, input logic [VW-1:0] avc,
                       input logic sv, input logic [NI-1:0] ssel, input logic tail, input logic [NI-1:0] rd,
                       input logic [NI-1:0] e_req, input logic [NI-1:0] e_act,
                       input logic [VW-1:0] e_vc, input logic [PW-1:0] e_port, input logic e_err);
        vecs[nv] = '{rst, rv, rsel, rop, av, asel, avc, sv, ssel, tail, rd,
                     e_req, e_act, e_vc, e_port, e_err};
        nv++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; route_valid = 1'b0; route_ivc_sel = '0; route_oport = '0;
        alloc_enable = 1'b0; alloc_ivc_sel = '0; allocated_vc = '0;
        send_valid = 1'b0; send_ivc_sel = '0; send_tail = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rd_ivc_sel = '0;

        //  rst rv rsel    rop av asel    avc sv ssel    tl rd       req     act     vc port err
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0); // reset
        add(0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0); // idle
        add(0, 1, 10'h008, 5, 0, 10'h000, 0, 0, 10'h000, 0, 10'h008, 10'h008, 10'h000, 0, 5, 0); // route VC3
        add(0, 0, 10'h000, 0, 1, 10'h008, 2, 0, 10'h000, 0, 10'h008, 10'h000, 10'h008, 2, 5, 0); // alloc VC3
        add(0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 10'h008, 0, 10'h008, 10'h000, 10'h008, 2, 5, 0); // body send
        add(0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 10'h008, 1, 10'h008, 10'h000, 10'h000, 2, 5, 0); // tail send
        add(0, 1, 10'h080, 4, 0, 10'h000, 0, 0, 10'h000, 0, 10'h080, 10'h080, 10'h000, 0, 4, 0); // route VC7
        add(0, 0, 10'h000, 0, 1, 10'h080, 1, 0, 10'h000, 0, 10'h080, 10'h000, 10'h080, 1, 4, 0); // alloc VC7
        add(0, 1, 10'h080, 2, 0, 10'h000, 0, 1, 10'h080, 1, 10'h080, 10'h080, 10'h000, 0, 2, 0); // back-to-back
        add(0, 1, 10'h010, 6, 0, 10'h000, 0, 0, 10'h000, 0, 10'h010, 10'h090, 10'h000, 0, 6, 0); // route VC4
        add(0, 1, 10'h200, 3, 0, 10'h000, 0, 0, 10'h000, 0, 10'h200, 10'h290, 10'h000, 0, 3, 0); // route VC9
        add(0, 0, 10'h000, 0, 1, 10'h200, 1, 0, 10'h000, 0, 10'h200, 10'h090, 10'h200, 1, 3, 0); // alloc VC9
        add(0, 1, 10'h001, 1, 1, 10'h010, 3, 1, 10'h200, 1, 10'h011, 10'h081, 10'h010, 3, 7, 0); // concurrent
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0); // reset
        add(0, 1, 10'h002, 2, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h002, 10'h000, 0, 0, 0); // route VC1
        add(0, 1, 10'h004, 7, 1, 10'h002, 3, 0, 10'h000, 0, 10'h000, 10'h004, 10'h002, 0, 0, 0); // alloc1 route2
        add(0, 1, 10'h040, 1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h044, 10'h002, 0, 0, 0); // route VC6
        add(1, 1, 10'h008, 4, 1, 10'h004, 1, 1, 10'h002, 1, 10'h046, 10'h000, 10'h000, 0, 0, 0); // reset mid-op
        add(0, 0, 10'h000, 0, 1, 10'h004, 1, 0, 10'h000, 0, 10'h004, 10'h000, 10'h000, 0, 0, 1); // alloc IDLE VC2
        add(0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h004, 10'h000, 10'h000, 0, 0, 1); // error sticky
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0); // reset
        add(0, 1, 10'h020, 3, 0, 10'h000, 0, 0, 10'h000, 0, 10'h020, 10'h020, 10'h000, 0, 3, 0); // route VC5
        add(0, 0, 10'h000, 0, 1, 10'h020, 2, 0, 10'h000, 0, 10'h020, 10'h000, 10'h020, 2, 3, 0); // alloc VC5
        add(0, 1, 10'h020, 6, 0, 10'h000, 0, 0, 10'h000, 0, 10'h020, 10'h000, 10'h020, 2, 3, 1); // route ACTIVE
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0); // reset
        add(0, 1, 10'h001, 1, 0, 10'h000, 0, 0, 10'h000, 0, 10'h003, 10'h001, 10'h000, 0, 1, 0); // route VC0
        add(0, 1, 10'h002, 2, 0, 10'h000, 0, 0, 10'h000, 0, 10'h003, 10'h003, 10'h000, 0, 3, 0); // route VC1
        add(0, 0, 10'h000, 0, 1, 10'h001, 1, 0, 10'h000, 0, 10'h003, 10'h002, 10'h001, 1, 3, 0); // alloc VC0
        add(0, 0, 10'h000, 0, 1, 10'h002, 2, 0, 10'h000, 0, 10'h003, 10'h000, 10'h003, 3, 3, 0); // alloc VC1
        add(0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 10'h003, 1, 10'h003, 10'h000, 10'h003, 3, 3, 1); // send multi-hot
        add(1, 0, 10'h000, 0, 0, 10'h000, 0, 0, 10'h000, 0, 10'h000, 10'h000, 10'h000, 0, 0, 0); // reset
        add(0, 1, 10'h000, 5, 0, 10'h000, 0, 0, 10'h000, 0, 10'h3FF, 10'h000, 10'h000, 0, 0, 1); // route sel zero

        for (int i = 0; i < nv; i++) begin
            @(negedge clock);
            reset = vecs[i].rst;
            route_valid = vecs[i].rv;  route_ivc_sel = vecs[i].rsel; route_oport = vecs[i].rop;
            alloc_enable = vecs[i].av; alloc_ivc_sel = vecs[i].asel; allocated_vc = vecs[i].avc;
            send_valid = vecs[i].sv;   send_ivc_sel = vecs[i].ssel;  send_tail = vecs[i].tail;
            rd_ivc_sel = vecs[i].rd;
            @(posedge clock);
            #1;
            applied++;
            check("vc_req",        i, 32'(vc_req),        32'(vecs[i].e_req));
            check("vc_active",     i, 32'(vc_active),     32'(vecs[i].e_act));
            check("assigned_vc",   i, 32'(assigned_vc),   32'(vecs[i].e_vc));
            check("assigned_port", i, 32'(assigned_port), 32'(vecs[i].e_port));
            check("error",         i, 32'(error),         32'(vecs[i].e_err));
        end

        // Pre-edge visibility and zero-latency read path on VC8.
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        idle_inputs();
        route_valid = 1'b1; route_ivc_sel = 10'h100; route_oport = 3'd5;
        rd_ivc_sel = 10'h100;
        #1;
        applied++;
        check("pre_edge_req",  100, 32'(vc_req),        32'h0);
        check("pre_edge_port", 100, 32'(assigned_port), 32'h0);
        @(posedge clock);
        #1;
        applied++;
        check("post_edge_req",  101, 32'(vc_req),        32'h100);
        check("post_edge_port", 101, 32'(assigned_port), 32'h5);
        @(negedge clock);
        idle_inputs();
        rd_ivc_sel = 10'h001;
        #1;
        applied++;
        check("rd_switch_port", 102, 32'(assigned_port), 32'h0);
        rd_ivc_sel = 10'h100;
        #1;
        applied++;
        check("rd_back_port", 103, 32'(assigned_port), 32'h5);
        check("final_error",  103, 32'(error),         32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
